operand_entry: RTL

- Input-side counterpart to the seven-segment display path: turns board push-buttons and slide switches into the 32-bit operand vectors A and B consumed by the dot-product datapath and the display.
- Debounces buttons, writes one 8-bit element per load press, and sequences a start/done handshake with the dot-product unit.
- Locks entry while a result is pending or being shown.

---
 rtl/operand_entry_pkg.sv | 32 +++
 rtl/operand_entry_if.sv | 32 +++
 rtl/operand_entry_btn_debounce.sv | 59 +++++
 rtl/operand_entry.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block: controller state encoding,
// element geometry and the helpers that place one 8-bit element into a
// 32-bit operand vector (element 0 is the most significant byte).
package operand_entry_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 4;
    localparam int VEC_W  = ELEM_W * N_ELEM;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Bit offset of the least significant bit of element idx.
    function automatic logic [4:0] elem_lsb(input logic [1:0] idx);
        return 5'd24 - {idx, 3'b000};
    endfunction

    // Return vec with element idx replaced by val.
    function automatic logic [VEC_W-1:0] put_elem(input logic [VEC_W-1:0]  vec,
                                                  input logic [1:0]        idx,
                                                  input logic [ELEM_W-1:0] val);
        logic [VEC_W-1:0] res;
        res = vec;
        res[elem_lsb(idx) +: ELEM_W] = val;
        return res;
    endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Board-side and dot-product-side signals of the operand entry block.
// slave: the operand entry block itself; master: the board / surrounding logic.
interface operand_entry_if;

    logic        btn_load;
    logic        btn_clear;
    logic        btn_compute;
    logic [7:0]  sw_value;
    logic [1:0]  sw_index;
    logic        sel_a;
    logic        sel_b;
    logic        done;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        result_valid;
    logic        entry_locked;
    logic        load_err;

    modport slave (
        input  btn_load, btn_clear, btn_compute,
        input  sw_value, sw_index, sel_a, sel_b, done,
        output A, B, start, result_valid, entry_locked, load_err
    );

    modport master (
        output btn_load, btn_clear, btn_compute,
        output sw_value, sw_index, sel_a, sel_b, done,
        input  A, B, start, result_valid, entry_locked, load_err
    );

endinterface

// File: rtl/operand_entry_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability
// counter. The accepted level follows the synchronised level only after it has
// held for DEBOUNCE_CYCLES cycles; press is a registered one-cycle pulse on an
// accepted rising edge. Raw edge to press: 2 + DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept the synchronised level once it has been stable long enough; any
    // return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/operand_entry.sv
// Operand entry controller: debounces the load/clear/compute buttons, writes
// one element of operand vector A or B per load press and runs the start/done
// handshake with the dot-product unit. Entry is locked from start until the
// held result is dismissed.
// Build option: define AUTO_INDEX_EN to replace sw_index with an internal
// write pointer that advances after every successful write.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_entry_if.slave  bus
);

    logic load_p_s;
    logic clear_p_s;
    logic compute_p_s;
    logic load_lvl_s;
    logic clear_lvl_s;
    logic compute_lvl_s;

    state_t           state_r;
    logic [VEC_W-1:0] a_r;
    logic [VEC_W-1:0] b_r;
    logic             start_r;
    logic             result_valid_r;
    logic             entry_locked_r;
    logic             load_err_r;
    logic [1:0]       widx_s;
    logic             one_sel_s;
    logic             locked_load_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_load),
        .level (load_lvl_s),
        .press (load_p_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_clear),
        .level (clear_lvl_s),
        .press (clear_p_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_compute (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_compute),
        .level (compute_lvl_s),
        .press (compute_p_s)
    );

`ifdef AUTO_INDEX_EN
    logic [1:0] wptr_r;
    logic       levels_unused_s;

    assign widx_s          = wptr_r;
    assign levels_unused_s = ^{load_lvl_s, clear_lvl_s, compute_lvl_s, bus.sw_index};

    // Write pointer: advances on each accepted write, cleared by clear press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= 2'd0;
        end else if (clear_p_s) begin
            wptr_r <= 2'd0;
        end else if ((state_r == ENTRY) && !compute_p_s && load_p_s && one_sel_s) begin
            wptr_r <= wptr_r + 2'd1;
        end else begin
            wptr_r <= wptr_r;
        end
    end
`else
    logic levels_unused_s;

    assign widx_s          = bus.sw_index;
    assign levels_unused_s = ^{load_lvl_s, clear_lvl_s, compute_lvl_s};
`endif

    // Exactly one target vector selected.
    assign one_sel_s     = bus.sel_a ^ bus.sel_b;
    // A load that survives press priority (compute wins over load).
    assign locked_load_s = load_p_s & ~compute_p_s;

    // Controller: state, operand registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ENTRY;
            a_r            <= '0;
            b_r            <= '0;
            start_r        <= 1'b0;
            result_valid_r <= 1'b0;
            entry_locked_r <= 1'b0;
            load_err_r     <= 1'b0;
        end else begin
            start_r    <= 1'b0;
            load_err_r <= 1'b0;
            if (clear_p_s) begin
                // Clear beats every other press and abandons any computation.
                state_r        <= ENTRY;
                a_r            <= '0;
                b_r            <= '0;
                result_valid_r <= 1'b0;
                entry_locked_r <= 1'b0;
            end else begin
                case (state_r)
                    ENTRY: begin
                        if (compute_p_s) begin
                            state_r        <= START;
                            start_r        <= 1'b1;
                            entry_locked_r <= 1'b1;
                        end else if (load_p_s) begin
                            if (one_sel_s) begin
                                if (bus.sel_a) begin
                                    a_r <= put_elem(a_r, widx_s, bus.sw_value);
                                end else begin
                                    b_r <= put_elem(b_r, widx_s, bus.sw_value);
                                end
                            end else begin
                                load_err_r <= 1'b1;
                            end
                        end else begin
                            state_r <= ENTRY;
                        end
                    end
                    START: begin
                        state_r    <= WAIT;
                        load_err_r <= locked_load_s;
                    end
                    WAIT: begin
                        load_err_r <= locked_load_s;
                        if (bus.done) begin
                            state_r        <= HOLD;
                            result_valid_r <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                    HOLD: begin
                        // A load press only dismisses the result; it never writes.
                        if (locked_load_s) begin
                            load_err_r     <= 1'b1;
                            state_r        <= ENTRY;
                            result_valid_r <= 1'b0;
                            entry_locked_r <= 1'b0;
                        end else begin
                            state_r <= HOLD;
                        end
                    end
                    default: begin
                        state_r        <= ENTRY;
                        result_valid_r <= 1'b0;
                        entry_locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.A            = a_r;
    assign bus.B            = b_r;
    assign bus.start        = start_r;
    assign bus.result_valid = result_valid_r;
    assign bus.entry_locked = entry_locked_r;
    assign bus.load_err     = load_err_r;

endmodule
